mdu_iter: RTL and testbench



---
 rtl/mdu_iter.sv | 170 +++++++++++++++++
 tb/tb_mdu_iter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with divide-by-zero and signed-overflow early exits.
module mdu_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     AW      = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_b;
  logic [AW-1:0]   r_acc;
  logic            r_neg;
  logic            r_special;
  logic [XLEN-1:0] r_spec;
  logic [CNT_W-1:0] r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  // Operand preparation on the raw inputs, used only when start is accepted
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic            w_neg;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_spec;

  assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_sa       = w_a_signed & a[XLEN-1];
  assign w_sb       = w_b_signed & b[XLEN-1];
  assign w_abs_a    = w_sa ? (~a + XLEN'(1)) : a;
  assign w_abs_b    = w_sb ? (~b + XLEN'(1)) : b;
  // Remainder takes the dividend's sign; product and quotient take sa^sb
  assign w_neg      = (op[2] && op[1]) ? w_sa : (w_sa ^ w_sb);
  assign w_div0     = op[2] && (b == '0);
  assign w_ovf      = op[2] && !op[0] && (a == MIN_INT) && (b == '1);
  assign w_spec     = w_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_INT);

  // Shift-add multiply step: multiplier in acc low half, product grows from the top
  logic [XLEN-1:0] w_mcand;
  logic [XLEN:0]   w_mul_sum;
  logic [AW-1:0]   w_mul_next;

  assign w_mcand    = r_acc[0] ? r_b : '0;
  assign w_mul_sum  = {1'b0, r_acc[AW-1:XLEN]} + {1'b0, w_mcand};
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide step: partial remainder in acc high half, quotient shifts into low half
  logic [XLEN:0]   w_div_rem;
  logic [XLEN+1:0] w_div_sub;
  logic            w_div_ok;
  logic [AW-1:0]   w_div_next;

  assign w_div_rem  = r_acc[AW-1:XLEN-1];
  assign w_div_sub  = {1'b0, w_div_rem} - {2'b00, r_b};
  assign w_div_ok   = !w_div_sub[XLEN+1];
  assign w_div_next = w_div_ok ? {w_div_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                               : {r_acc[AW-2:0], 1'b0};

  // Sign fix-up and result select at FIN
  logic [AW-1:0]   w_prod;
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fin;

  assign w_prod = r_neg ? (~r_acc + AW'(1)) : r_acc;
  assign w_quot = r_neg ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg ? (~r_acc[AW-1:XLEN] + XLEN'(1)) : r_acc[AW-1:XLEN];

  always_comb begin
    w_fin = w_quot;
    if (r_special) begin
      w_fin = r_spec;
    end else begin
      case (r_op)
        3'b000:                 w_fin = w_prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_fin = w_prod[AW-1:XLEN];
        3'b100, 3'b101:         w_fin = w_quot;
        default:                w_fin = w_rem;
      endcase
    end
  end

  // Control FSM with registered outputs; kill overrides every transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_special <= 1'b0;
      r_spec    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      if (kill) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_op      <= op;
              r_b       <= w_abs_b;
              r_acc     <= {XLEN'(0), w_abs_a};
              r_neg     <= w_neg;
              r_special <= w_div0 | w_ovf;
              r_spec    <= w_spec;
              r_cnt     <= '0;
              r_busy    <= 1'b1;
              r_state   <= (w_div0 | w_ovf) ? S_FIN : S_CALC;
            end
          end
          S_CALC: begin
            r_acc <= r_op[2] ? w_div_next : w_mul_next;
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_state <= S_FIN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_FIN: begin
            r_result <= w_fin;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed RV32M vectors, special cases, kill,
// mid-operation reset, start-while-busy and randomized ops against a reference model.
module tb_mdu_iter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_res = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 32'h0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Reference model built on native 64-bit and signed 32-bit arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic [63:0]        ux;
    logic [63:0]        uy;
    logic [63:0]        p;
    logic signed [31:0] x32;
    logic signed [31:0] y32;
    logic               ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'h0, x};
    uy  = {32'h0, y};
    x32 = x;
    y32 = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = 64'h0;
    case (o)
      3'b000: begin p = sx * sy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * $signed(uy); return p[63:32]; end
      3'b011: begin p = ux * uy; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(x32 / y32);
      end
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return 32'(x32 % y32);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Issue one op, push its expectation, then wait (bounded) for done and score it.
  // poke >= 0 pulses start again at that many edges after the sampling edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input string tag, input int poke);
    exp_t e;
    int   lat;
    int   bcnt;
    int   ndone;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    e.res = exp_res;
    e.lat = is_special(o, x, y) ? 1 : 33;
    e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 80) begin
      if (busy) bcnt++;
      start = (lat == poke);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    if (!done) begin
      check({e.tag, "_timeout"}, 64'(done), 64'(1));
    end else begin
      check({e.tag, "_result"}, 64'(result), 64'(e.res));
      check({e.tag, "_latency"}, 64'(lat), 64'(e.lat));
      check({e.tag, "_busy_cycles"}, 64'(bcnt), 64'(e.lat));
      last_res = e.res;
    end
    @(negedge clk);
    check({e.tag, "_done_one_cycle"}, 64'(done), 64'(0));
    if (poke >= 0) begin
      ndone = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check({e.tag, "_no_extra_done"}, 64'(ndone), 64'(0));
      check({e.tag, "_result_held"}, 64'(result), 64'(e.res));
    end
  endtask

  // Start an op and kill it kill_at edges after the sampling edge
  task automatic kill_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int kill_at, input string tag);
    int ndone;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    repeat (kill_at) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_result_kept"}, 64'(result), 64'(last_res));
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check({tag, "_no_done"}, 64'(ndone), 64'(0));
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'b000; a = 32'h0; b = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    rst = 1'b0;

    run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul",       -1);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh",      -1);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu",     -1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu",    -1);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div",       -1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem",       -1);
    run_op(3'b101, 32'd100,       32'd7,         32'd14,        "divu",      -1);
    run_op(3'b111, 32'd100,       32'd7,         32'd2,         "remu",      -1);
    run_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0",  -1);
    run_op(3'b110, 32'd5,         32'd0,         32'd5,         "rem_by0",   -1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",   -1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_ovf",   -1);

    kill_op(3'b100, 32'd1000, 32'd3, 9, "kill_calc");
    run_op(3'b100, 32'd1000, 32'd3, 32'd333, "after_kill", -1);
    kill_op(3'b101, 32'd9, 32'd0, 0, "kill_fin");

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd12345; b = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    last_res = 32'h0;
    @(negedge clk);
    rst = 1'b0;

    run_op(3'b000, 32'd12345, 32'd678, 32'd8369910, "mul_poke", 5);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 :
           (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom);
      if (i % 3 == 0) rb = rb >> $urandom_range(4, 28);
      run_op(ro, ra, rb, ref_mdu(ro, ra, rb), $sformatf("rand%0d_op%0d", i, ro), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
